// File: rtl/vid_addr_scaler_seq_if.sv
// rtl/vid_addr_scaler_seq_if.sv - DTG coordinate inputs and world-map address outputs
// The DTG side drives the master modport; the scaler consumes the slave modport.
interface vid_addr_scaler_seq_if #(
  parameter int COORD_W    = 12,
  parameter int MAP_W_BITS = 7,
  parameter int MAP_H_BITS = 7
);
  logic                             pix_en;
  logic                             video_on;
  logic [COORD_W-1:0]               pixel_row;
  logic [COORD_W-1:0]               pixel_column;
  logic [MAP_H_BITS+MAP_W_BITS-1:0] vid_addr;
  logic                             addr_valid;
  logic                             sync_err;

  modport master (
    output pix_en, video_on, pixel_row, pixel_column,
    input  vid_addr, addr_valid, sync_err
  );

  modport slave (
    input  pix_en, video_on, pixel_row, pixel_column,
    output vid_addr, addr_valid, sync_err
  );
endinterface

// File: rtl/vid_addr_scaler_seq.sv
// rtl/vid_addr_scaler_seq.sv - raster coordinate to world-map address scaler with sync tracking
// Map position follows the scan through sub-pixel counters, so no division is needed.
module vid_addr_scaler_seq #(
  parameter int COORD_W    = 12,
  parameter int MAP_W_BITS = 7,
  parameter int MAP_H_BITS = 7,
  parameter int SCALE_X    = 8,
  parameter int SCALE_Y    = 6,
  parameter int X_OFF      = 0,
  parameter int Y_OFF      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  vid_addr_scaler_seq_if.slave  bus
);
  localparam int CW1 = COORD_W + 1;
  localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  // Window bounds carry one extra bit so the end coordinate cannot wrap.
  localparam logic [CW1-1:0] X_LO    = CW1'(X_OFF);
  localparam logic [CW1-1:0] X_HI    = CW1'(X_OFF + SCALE_X * (2 ** MAP_W_BITS) - 1);
  localparam logic [CW1-1:0] Y_LO    = CW1'(Y_OFF);
  localparam logic [CW1-1:0] Y_HI    = CW1'(Y_OFF + SCALE_Y * (2 ** MAP_H_BITS) - 1);
  localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
  localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);
  localparam logic [CW1-1:0] C_ONE   = CW1'(1);

  logic [COORD_W-1:0]    prev_col_q, prev_row_q;
  logic [SXW-1:0]        col_sub_q, col_sub_d;
  logic [SYW-1:0]        row_sub_q, row_sub_d;
  logic [MAP_W_BITS-1:0] map_col_q, map_col_d;
  logic [MAP_H_BITS-1:0] map_row_q, map_row_d;
  logic                  col_lock_q, col_lock_d;
  logic                  row_lock_q, row_lock_d;
  logic                  in_win_q, video_on_q, sync_err_q;
  logic [MAP_H_BITS+MAP_W_BITS-1:0] vid_addr_q;
  logic                  addr_valid_q;

  logic [CW1-1:0] col_x, row_x, prev_col_x, prev_row_x;
  logic           col_in, row_in, col_err, row_err, row_eval;

  assign col_x      = {1'b0, bus.pixel_column};
  assign row_x      = {1'b0, bus.pixel_row};
  assign prev_col_x = {1'b0, prev_col_q};
  assign prev_row_x = {1'b0, prev_row_q};
  assign col_in     = (col_x >= X_LO) && (col_x <= X_HI);
  assign row_in     = (row_x >= Y_LO) && (row_x <= Y_HI);
  assign row_eval   = (row_x != prev_row_x) || ((row_x == Y_LO) && !row_lock_q);

  always_comb begin
    col_sub_d  = col_sub_q;
    map_col_d  = map_col_q;
    col_lock_d = col_lock_q;
    col_err    = 1'b0;
    if (col_x == X_LO) begin
      col_sub_d  = '0;
      map_col_d  = '0;
      col_lock_d = 1'b1;
    end else if ((col_x == prev_col_x + C_ONE) && col_lock_q && col_in) begin
      if (col_sub_q == SX_LAST) begin
        col_sub_d = '0;
        map_col_d = map_col_q + MAP_W_BITS'(1);
      end else begin
        col_sub_d = col_sub_q + SXW'(1);
      end
    end else if ((col_x != prev_col_x) && col_in) begin
      col_lock_d = 1'b0;
      col_err    = 1'b1;
    end
  end

  // The row axis only moves on a row change, or to acquire lock on the first window row.
  always_comb begin
    row_sub_d  = row_sub_q;
    map_row_d  = map_row_q;
    row_lock_d = row_lock_q;
    row_err    = 1'b0;
    if (row_eval) begin
      if (row_x == Y_LO) begin
        row_sub_d  = '0;
        map_row_d  = '0;
        row_lock_d = 1'b1;
      end else if ((row_x == prev_row_x + C_ONE) && row_lock_q && row_in) begin
        if (row_sub_q == SY_LAST) begin
          row_sub_d = '0;
          map_row_d = map_row_q + MAP_H_BITS'(1);
        end else begin
          row_sub_d = row_sub_q + SYW'(1);
        end
      end else if ((row_x != prev_row_x) && row_in) begin
        row_lock_d = 1'b0;
        row_err    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_col_q   <= '1;
      prev_row_q   <= '1;
      col_sub_q    <= '0;
      row_sub_q    <= '0;
      map_col_q    <= '0;
      map_row_q    <= '0;
      col_lock_q   <= 1'b0;
      row_lock_q   <= 1'b0;
      in_win_q     <= 1'b0;
      video_on_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      vid_addr_q   <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      if (bus.pix_en) begin
        prev_col_q <= bus.pixel_column;
        prev_row_q <= bus.pixel_row;
        col_sub_q  <= col_sub_d;
        row_sub_q  <= row_sub_d;
        map_col_q  <= map_col_d;
        map_row_q  <= map_row_d;
        col_lock_q <= col_lock_d;
        row_lock_q <= row_lock_d;
        in_win_q   <= col_in & row_in;
        video_on_q <= bus.video_on;
        sync_err_q <= sync_err_q | col_err | row_err;
      end
      vid_addr_q   <= {map_row_q, map_col_q};
      addr_valid_q <= video_on_q & in_win_q & col_lock_q & row_lock_q;
    end
  end

  assign bus.vid_addr   = vid_addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_vid_addr_scaler_seq.sv
// tb/tb_vid_addr_scaler_seq.sv - scoreboard bench for three scaler configurations on one raster
// Expected map addresses come from plain division of window-relative coordinates.
module tb_vid_addr_scaler_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1, pix_en = 1'b0, video_on = 1'b0;
  logic [11:0] pixel_row = '0, pixel_column = '0;

  always #5 clk = ~clk;

  vid_addr_scaler_seq_if #(.COORD_W(12), .MAP_W_BITS(7), .MAP_H_BITS(7)) if_a ();
  vid_addr_scaler_seq_if #(.COORD_W(12), .MAP_W_BITS(7), .MAP_H_BITS(7)) if_b ();
  vid_addr_scaler_seq_if #(.COORD_W(12), .MAP_W_BITS(3), .MAP_H_BITS(2)) if_c ();

  assign if_a.pix_en = pix_en;  assign if_a.video_on = video_on;
  assign if_a.pixel_row = pixel_row;  assign if_a.pixel_column = pixel_column;
  assign if_b.pix_en = pix_en;  assign if_b.video_on = video_on;
  assign if_b.pixel_row = pixel_row;  assign if_b.pixel_column = pixel_column;
  assign if_c.pix_en = pix_en;  assign if_c.video_on = video_on;
  assign if_c.pixel_row = pixel_row;  assign if_c.pixel_column = pixel_column;

  vid_addr_scaler_seq u_a (.clk(clk), .reset(reset), .bus(if_a));
  vid_addr_scaler_seq #(.X_OFF(128), .Y_OFF(64), .SCALE_X(4), .SCALE_Y(4))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  vid_addr_scaler_seq #(.MAP_W_BITS(3), .MAP_H_BITS(2), .SCALE_X(1), .SCALE_Y(3), .X_OFF(5), .Y_OFF(2))
    u_c (.clk(clk), .reset(reset), .bus(if_c));

  int p_xo[3] = '{0, 128, 5};
  int p_yo[3] = '{0, 64, 2};
  int p_sx[3] = '{8, 4, 1};
  int p_sy[3] = '{6, 4, 3};
  int p_wb[3] = '{7, 7, 3};
  int p_hb[3] = '{7, 7, 2};

  typedef struct {
    int due;
    int dut;
    bit is_err;
    bit chk;
    bit val;
    int addr;
  } exp_t;

  exp_t sbq[$];
  int   edge_no = 0;
  int   checks = 0;
  int   errors = 0;

  int m_pc[3], m_pr[3];
  bit m_lc[3], m_lr[3], m_err[3];

  bit known[3], e_err[3], e_val[3], e_chk[3];
  int e_addr[3];

  function automatic void push(int due, int d, bit is_err, bit chk, bit val, int addr);
    exp_t e;
    e.due = due; e.dut = d; e.is_err = is_err; e.chk = chk; e.val = val; e.addr = addr;
    sbq.push_back(e);
  endfunction

  task automatic axis(input int cur, input int prev, input int lo, input int hi,
                      input bit lk, output bit lk_o, output bit er_o);
    lk_o = lk;
    er_o = 1'b0;
    if (cur == lo) lk_o = 1'b1;
    else if (cur != prev && cur >= lo && cur <= hi && !(lk && cur == prev + 1)) begin
      lk_o = 1'b0;
      er_o = 1'b1;
    end
  endtask

  task automatic model(input bit rst, input bit en, input bit vo, input int row, input int col);
    bit nv[3];
    int na[3];
    if (!rst && !en) return;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_pc[d] = 4095; m_pr[d] = 4095;
        m_lc[d] = 1'b0; m_lr[d] = 1'b0; m_err[d] = 1'b0;
        nv[d] = 1'b0; na[d] = 0;
      end else begin
        int xe, ye;
        bit lc, lr, ec, er, inw;
        xe = p_xo[d] + p_sx[d] * (1 << p_wb[d]) - 1;
        ye = p_yo[d] + p_sy[d] * (1 << p_hb[d]) - 1;
        axis(col, m_pc[d], p_xo[d], xe, m_lc[d], lc, ec);
        axis(row, m_pr[d], p_yo[d], ye, m_lr[d], lr, er);
        m_lc[d] = lc; m_lr[d] = lr; m_pc[d] = col; m_pr[d] = row;
        m_err[d] = m_err[d] | ec | er;
        inw = (col >= p_xo[d]) && (col <= xe) && (row >= p_yo[d]) && (row <= ye);
        nv[d] = vo && inw && lc && lr;
        na[d] = ((((row - p_yo[d]) / p_sy[d]) % (1 << p_hb[d])) << p_wb[d])
              | (((col - p_xo[d]) / p_sx[d]) % (1 << p_wb[d]));
      end
      push(edge_no + 1, d, 1'b1, 1'b0, m_err[d], 0);
    end
    if (rst) for (int d = 0; d < 3; d++) push(edge_no + 1, d, 1'b0, 1'b1, 1'b0, 0);
    for (int d = 0; d < 3; d++) push(edge_no + 2, d, 1'b0, rst | nv[d], nv[d], na[d]);
  endtask

  task automatic step(input bit rst, input bit en, input int row, input int col, input bit noise);
    bit vo;
    vo = (row < 768) && (col < 1024);
    if (noise && $urandom_range(0, 5) == 0) vo = 1'b0;
    reset = rst; pix_en = en; video_on = vo;
    pixel_row = 12'(row); pixel_column = 12'(col);
    model(rst, en, vo, row, col);
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  // mode 0: strobe every clk, 1: every 4th clk with inputs held, 2: random gaps with junk inputs
  task automatic line(input int row, input int ncols, input int mode, input int rst_col,
                      input bit jump, input bit noise);
    int c;
    c = 0;
    while (c < ncols) begin
      step(c == rst_col, 1'b1, row, c, noise);
      if (mode == 1) repeat (3) step(1'b0, 1'b0, row, c, 1'b0);
      else if (mode == 2)
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0);
      c = (jump && c == 100) ? 300 : c + 1;
    end
  endtask

  task automatic frame(input int first, input int last, input int rst_row);
    for (int r = first; r <= last; r++) begin
      bit full;
      full = (r < 8) || (r >= 63 && r <= 65) || r == 300 || r == 767;
      line(r, full ? 1040 : $urandom_range(1, 16), 0, (r == rst_row) ? 500 : -1, 1'b0, 1'b0);
    end
  endtask

  function automatic int get_addr(int d);
    case (d)
      0: return int'(if_a.vid_addr);
      1: return int'(if_b.vid_addr);
      default: return int'(if_c.vid_addr);
    endcase
  endfunction

  function automatic bit get_val(int d);
    case (d)
      0: return if_a.addr_valid;
      1: return if_b.addr_valid;
      default: return if_c.addr_valid;
    endcase
  endfunction

  function automatic bit get_err(int d);
    case (d)
      0: return if_a.sync_err;
      1: return if_b.sync_err;
      default: return if_c.sync_err;
    endcase
  endfunction

  task automatic cmp(input string nm, input int d, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got 0x%0h expected 0x%0h", nm, d, edge_no, got, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= edge_no) begin
        e = sbq.pop_front();
        known[e.dut] = 1'b1;
        if (e.is_err) e_err[e.dut] = e.val;
        else begin
          e_val[e.dut]  = e.val;
          e_chk[e.dut]  = e.chk;
          e_addr[e.dut] = e.addr;
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (known[d]) begin
          cmp("sync_err", d, int'(get_err(d)), int'(e_err[d]));
          cmp("addr_valid", d, int'(get_val(d)), int'(e_val[d]));
          if (e_chk[d]) cmp("vid_addr", d, get_addr(d), e_addr[d]);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0);
    frame(0, 769, -1);
    line(0, 1040, 1, -1, 1'b0, 1'b0);
    line(1, 1040, 1, -1, 1'b0, 1'b0);
    line(2, 1040, 0, -1, 1'b1, 1'b0);
    line(3, 1040, 2, -1, 1'b0, 1'b0);
    frame(4, 769, 300);
    line(0, 1040, 2, -1, 1'b0, 1'b1);
    line(1, 1040, 0, -1, 1'b0, 1'b1);
    for (int r = 2; r <= 40; r++) line(r, $urandom_range(1, 16), 2, -1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    cmp("sb_drain", 0, sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vid_addr_scaler_seq.md
Name: vid_addr_scaler_seq

Overview:
Parametrised, sequential successor to the combinational pixel-to-map scaler. It converts the DTG raster coordinates (pixel_row, pixel_column) into a world-map video address of configurable map size. Scale factors may be any integer, including non-powers-of-two, and an offset display window is supported. Dividers are replaced by incremental sub-pixel counters that track the raster scan. The block sits between the DTG and the world-map / icon address inputs, and adds window-valid and sync-error status.

Parameters:
COORD_W, 12, width of pixel_row / pixel_column
MAP_W_BITS, 7, log2 of map width in tiles (map columns)
MAP_H_BITS, 7, log2 of map height in tiles (map rows)
SCALE_X, 8, display pixels per map column (integer >= 1)
SCALE_Y, 6, display pixels per map row (integer >= 1)
X_OFF, 0, first display column of the map window
Y_OFF, 0, first display row of the map window

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_en  in  1  pixel strobe; coordinates are sampled only when high
video_on  in  1  DTG active-video flag
pixel_row  in  COORD_W  current display row
pixel_column  in  COORD_W  current display column
vid_addr  out  MAP_H_BITS+MAP_W_BITS  {map_row, map_col}
addr_valid  out  1  video_on, inside window, and both axes locked
sync_err  out  1  sticky flag: non-sequential coordinate step inside the window

Behaviour:
- Window bounds: X_END = X_OFF + SCALE_X*2^MAP_W_BITS - 1 and Y_END = Y_OFF + SCALE_Y*2^MAP_H_BITS - 1. in_win = (X_OFF <= col <= X_END) and (Y_OFF <= row <= Y_END). All compares are unsigned at COORD_W+1 bits, so X_END/Y_END overflow is not possible.
- Stage 1 is updated only on clk edges with pix_en=1. It holds prev_col, prev_row, col_sub, map_col, col_lock, row_sub, map_row, row_lock, the registered in_win and video_on, and sync_err.
- Column axis, evaluated per sample:
  - col == X_OFF: col_sub=0, map_col=0, col_lock=1.
  - col == prev_col+1, col_lock=1, col inside [X_OFF, X_END]: if col_sub == SCALE_X-1 then col_sub=0 and map_col++, else col_sub++.
  - col == prev_col: hold.
  - Otherwise, with col inside the window: col_lock=0 and sync_err=1.
  - Otherwise, with col outside the window: no change. This covers the end-of-line wrap.
- Row axis: same rules using row, prev_row, Y_OFF, Y_END, SCALE_Y, row_sub, map_row, row_lock. The row axis evaluates only when row != prev_row, or when row == Y_OFF and row_lock == 0.
- Simultaneous column wrap and row step in one sample: both axes update independently in the same cycle.
- map_col and map_row wrap modulo 2^MAP_W_BITS and 2^MAP_H_BITS. Within the window they never exceed their maxima. Past X_END/Y_END their values are don't-care, masked by addr_valid.
- Stage 2 updates every clk edge: vid_addr <= {map_row, map_col}; addr_valid <= video_on_s1 & in_win_s1 & col_lock & row_lock.
- Latency: a coordinate sampled with pix_en=1 at edge N appears on vid_addr/addr_valid after edge N+1. Outputs hold while pix_en=0.
- Lost lock recovers automatically at the next col == X_OFF (column) or row == Y_OFF (row). sync_err stays 1 until reset.
- Reset: all outputs and state go to 0, including vid_addr=0, addr_valid=0, sync_err=0, col_lock=0 and row_lock=0. prev_col and prev_row reset to all-ones, so the first sample of 0 is treated as the window start. Reset asserted mid-frame aborts immediately. Addresses remain invalid until the first X_OFF column and Y_OFF row are seen.
- SCALE_X=1 or SCALE_Y=1: the sub-counter is constantly 0 and the map counter increments on every step.
- Implementation: no dividers and no multipliers in logic. Only constant products appear, in the parameter expressions.

Test Plan:
- Defaults, full 1024x768 raster scan with pix_en=1 every clk -> at (row 0, col 0..7) vid_addr=0x0000; at col 8 map_col=1; at (row 6, col 1016) vid_addr={7'd1,7'd127}=0x00FF. addr_valid=1 throughout active video; sync_err=0 at end of frame.
- Defaults, (row 767, col 1023) -> vid_addr=0x3FFF two edges after sampling; the next sample (row 0, col 0) -> vid_addr=0x0000.
- X_OFF=128, Y_OFF=64, SCALE_X=SCALE_Y=4 -> col 127 gives addr_valid=0; col 128 gives map_col=0; col 132 gives map_col=1; col 640 (X_END+1) gives addr_valid=0; row 63 gives addr_valid=0 and sync_err=0.
- Column jump from 100 to 300 mid-line (defaults) -> sync_err=1, addr_valid=0 for the rest of the line. At the next line's col 0, addr_valid returns to 1 with the correct addresses; sync_err stays 1.
- pix_en asserted every 4th clk, with the coordinates held between strobes -> addresses identical to the pix_en=1 run, each updating exactly 2 edges after its strobe and held otherwise.
- Reset pulsed for one clk at (row 300, col 500) -> outputs 0 on the next edge. addr_valid stays 0 until row 0 / col 0 of the next frame, then the addresses are correct.
